spi_regfile_peripheral: RTL and testbench

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

---
 rtl/spi_regfile_pkg.sv | 27 ++
 rtl/spi_regfile_peripheral_if.sv | 17 +
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_regfile_peripheral.sv | 179 +++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// ============================================================================
// spi_regfile_pkg : shared constants, FSM encoding and helpers for the SPI
//                   register-file peripheral.  Rev 1.0
// ============================================================================
`default_nettype none

package spi_regfile_pkg;

  localparam int CMD_BITS = 8;
  localparam int ADDR_W   = 7;
  localparam int RW_BIT   = 7;     // position of R/W inside the command byte
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_regfile_peripheral_if.sv
// ============================================================================
// spi_regfile_peripheral_if : SPI pad-side signal bundle (mode 0).  Rev 1.0
// ============================================================================
`default_nettype none

interface spi_regfile_peripheral_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, output COPI, output nCS, input CIPO, input cipo_oe);
  modport slave  (input SCLK, input COPI, input nCS, output CIPO, output cipo_oe);
endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : STAGES-deep synchroniser with registered rise/fall pulses.
//                 Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // level_q is the previous synchronised value, so it lines up with the pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {STAGES{RST_VAL}};
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
// ============================================================================
// spi_regfile_peripheral : mode-0 SPI target exposing NUM_REGS registers of
//                          DATA_W bits with write-on-deselect commit.  Rev 1.0
// ============================================================================
`default_nettype none

module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_BITS = CMD_BITS + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int SETTLE     = SYNC_STAGES + 1;

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_copi_level, w_copi_rise, w_copi_fall;
  logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
  logic w_unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_i(spi.SCLK),
    .level_o(w_sclk_level), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .async_i(spi.COPI),
    .level_o(w_copi_level), .rise_o(w_copi_rise), .fall_o(w_copi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_i(spi.nCS),
    .level_o(w_ncs_level), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
  );

  assign w_unused_sync = ^{w_sclk_level, w_copi_rise, w_copi_fall};

  state_e                    state_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [FRAME_BITS-1:0]     shift_in_q;
  logic [DATA_W-1:0]         shift_out_q;
  logic                      cipo_q;
  logic                      wr_strobe_q;
  logic                      frame_err_q;
  logic [ADDR_W-1:0]         wr_addr_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                      armed_q;
  logic [2:0]                settle_q;

  logic [FRAME_BITS-1:0] w_shift_next;
  logic [CMD_BITS-1:0]   w_cmd_now;
  logic [ADDR_W-1:0]     w_cmd_addr;
  logic                  w_cmd_rd;
  logic [CMD_BITS-1:0]   w_frm_cmd;
  logic [ADDR_W-1:0]     w_frm_addr;
  logic                  w_frm_wr;
  logic [DATA_W-1:0]     w_frm_data;
  logic [DATA_W-1:0]     w_rd_data;

  assign w_shift_next = {shift_in_q[FRAME_BITS-2:0], w_copi_level};
  // command byte as it stands once the current sample is included
  assign w_cmd_now    = w_shift_next[CMD_BITS-1:0];
  assign w_cmd_addr   = w_cmd_now[ADDR_W-1:0];
  assign w_cmd_rd     = (w_cmd_now[RW_BIT] != RW_WRITE);
  assign w_frm_cmd    = shift_in_q[FRAME_BITS-1 -: CMD_BITS];
  assign w_frm_addr   = w_frm_cmd[ADDR_W-1:0];
  assign w_frm_wr     = (w_frm_cmd[RW_BIT] == RW_WRITE);
  assign w_frm_data   = shift_in_q[DATA_W-1:0];

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_cmd_addr == ADDR_W'(i)) w_rd_data = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // A fall is only accepted once nCS has been seen high after reset, so a
  // frame interrupted by reset cannot restart halfway through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      cipo_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      regs_q      <= RST_VAL;
      armed_q     <= 1'b0;
      settle_q    <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (settle_q != 3'(SETTLE)) settle_q <= settle_q + 1'b1;
      else if (w_ncs_level)       armed_q  <= 1'b1;

      if (w_ncs_rise) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        cipo_q    <= 1'b0;
        case (state_q)
          ST_CMD, ST_DATA: frame_err_q <= 1'b1;
          ST_DONE: begin
            if (w_frm_wr) begin
              if (addr_valid(w_frm_addr, NUM_REGS)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (w_frm_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= w_frm_data;
                end
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= w_frm_addr;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end else if (w_ncs_fall) begin
        if (armed_q) begin
          state_q    <= ST_CMD;
          bit_cnt_q  <= '0;
          shift_in_q <= '0;
          cipo_q     <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_CMD: begin
            if (w_sclk_rise) begin
              shift_in_q <= w_shift_next;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                state_q     <= ST_DATA;
                shift_out_q <= w_cmd_rd ? w_rd_data : '0;
              end
            end
          end
          ST_DATA: begin
            if (w_sclk_rise) begin
              shift_in_q <= w_shift_next;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                state_q <= ST_DONE;
                cipo_q  <= 1'b0;
              end
            end else if (w_sclk_fall) begin
              cipo_q      <= shift_out_q[DATA_W-1];
              shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.CIPO    = cipo_q;
  assign spi.cipo_oe = ~w_ncs_level;
  assign regs_flat   = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
// ============================================================================
// tb_spi_regfile_peripheral : drives 8-bit and 16-bit instances through SPI
//                             frames and checks them against a register model.
// ============================================================================
`default_nettype none

module tb_spi_regfile_peripheral;

  localparam int HALF = 6;   // SCLK half-period in clk cycles (SCLK = clk/12)
  localparam logic [39:0] RV8 = {8'h5A, 8'hC3, 8'h5C, 8'h7E, 8'h96};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if if8();
  spi_regfile_peripheral_if if16();

  logic [39:0] regs_flat8;
  logic [79:0] regs_flat16;
  logic        wr_strobe8, wr_strobe16, frame_err8, frame_err16;
  logic [6:0]  wr_addr8, wr_addr16;

  spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .SYNC_STAGES(2), .RST_VAL(RV8)) dut8 (
    .clk(clk), .rst(rst), .spi(if8), .regs_flat(regs_flat8),
    .wr_strobe(wr_strobe8), .wr_addr(wr_addr8), .frame_err(frame_err8));

  spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(16), .SYNC_STAGES(3), .RST_VAL(80'h0)) dut16 (
    .clk(clk), .rst(rst), .spi(if16), .regs_flat(regs_flat16),
    .wr_strobe(wr_strobe16), .wr_addr(wr_addr16), .frame_err(frame_err16));

  int n_chk = 0;
  int n_fail = 0;

  int st8 = 0, er8 = 0, st16 = 0, er16 = 0;
  logic [39:0] st_regs8 = '0;
  always @(negedge clk) begin
    if (wr_strobe8) begin st8++; st_regs8 = regs_flat8; end
    if (frame_err8) er8++;
    if (wr_strobe16) st16++;
    if (frame_err16) er16++;
  end

  logic [7:0] model8 [5];
  logic [6:0] last8;

  function automatic logic [39:0] flat8();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = model8[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins(input bit sel, input logic sclk, input logic copi, input logic ncs);
    if (sel) begin if16.SCLK = sclk; if16.COPI = copi; if16.nCS = ncs; end
    else     begin if8.SCLK  = sclk; if8.COPI  = copi; if8.nCS  = ncs; end
  endtask

  // Host side of one mode-0 frame; extra bits beyond the frame are sent as 1.
  task automatic do_frame(input bit sel, input bit wr, input logic [6:0] addr,
                          input logic [15:0] data, input int edges, input bit coinc,
                          output logic [15:0] rdata, output bit oe_ok, output bit cipo_ok);
    logic [23:0] f;
    int nb;
    logic b, c, oe;
    nb = sel ? 24 : 16;
    f  = sel ? {wr, addr, data} : {wr, addr, data[7:0], 8'h00};
    rdata = '0; oe_ok = 1'b1; cipo_ok = 1'b1;
    pins(sel, 1'b0, 1'b0, 1'b0);
    wait_clk(HALF);
    for (int k = 0; k <= edges; k++) begin
      b = (k < nb) ? f[23-k] : 1'b1;
      if (k == edges && !coinc) break;
      pins(sel, 1'b0, b, 1'b0);
      wait_clk(HALF);
      if (k == edges) begin
        pins(sel, 1'b1, b, 1'b1);
        wait_clk(HALF);
        pins(sel, 1'b0, b, 1'b1);
      end else begin
        pins(sel, 1'b1, b, 1'b0);
        c  = sel ? if16.CIPO : if8.CIPO;
        oe = sel ? if16.cipo_oe : if8.cipo_oe;
        if (oe !== 1'b1) oe_ok = 1'b0;
        if (k >= 8 && k < nb) rdata[nb-1-k] = c;
        else if (c !== 1'b0) cipo_ok = 1'b0;
        wait_clk(HALF);
        pins(sel, 1'b0, b, 1'b0);
      end
    end
    wait_clk(HALF);
    pins(sel, 1'b0, 1'b0, 1'b1);
    wait_clk(10);
  endtask

  task automatic run8(input string tag, input bit wr, input logic [6:0] addr, input logic [7:0] data,
                      input int edges, input bit coinc, input int exp_st, input int exp_er,
                      input logic [7:0] exp_rd);
    int st0, er0;
    logic [15:0] rd;
    bit oe_ok, cipo_ok;
    st0 = st8; er0 = er8;
    do_frame(1'b0, wr, addr, {8'h00, data}, edges, coinc, rd, oe_ok, cipo_ok);
    chk({tag, " strobe_count"}, 80'(st8 - st0), 80'(exp_st));
    chk({tag, " frame_err_count"}, 80'(er8 - er0), 80'(exp_er));
    if (!wr && edges >= 16 && !coinc) chk({tag, " read_data"}, 80'(rd[7:0]), 80'(exp_rd));
    chk({tag, " cipo_oe_in_frame"}, 80'(oe_ok), 80'(1));
    chk({tag, " cipo_zero_outside_data"}, 80'(cipo_ok), 80'(1));
    if (exp_st == 1) begin
      model8[addr] = data;
      last8 = addr;
      chk({tag, " regs_at_strobe"}, 80'(st_regs8[int'(addr)*8 +: 8]), 80'(data));
    end
    chk({tag, " regs_flat"}, 80'(regs_flat8), 80'(flat8()));
    chk({tag, " wr_addr"}, 80'(wr_addr8), 80'(last8));
    chk({tag, " idle_oe_cipo"}, 80'({if8.cipo_oe, if8.CIPO}), 80'(0));
  endtask

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    int         edges;
    bit         coinc;
    int         exp_st;
    int         exp_er;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [15:0] f;
    logic [15:0] rd;
    bit oe_ok, cipo_ok;
    int st0, er0, edges, r;
    bit wr;
    logic [6:0] addr;
    logic [7:0] data;

    tbl[0]  = '{1'b1, 7'h01, 8'hA5, 16, 1'b0, 1, 0, 8'h00};
    tbl[1]  = '{1'b0, 7'h01, 8'h00, 16, 1'b0, 0, 0, 8'hA5};
    tbl[2]  = '{1'b1, 7'h7F, 8'h33, 16, 1'b0, 0, 1, 8'h00};
    tbl[3]  = '{1'b0, 7'h05, 8'h00, 16, 1'b0, 0, 0, 8'h00};
    tbl[4]  = '{1'b1, 7'h02, 8'h3C, 12, 1'b0, 0, 1, 8'h00};
    tbl[5]  = '{1'b0, 7'h02, 8'h00, 16, 1'b0, 0, 0, 8'h5C};
    tbl[6]  = '{1'b1, 7'h00, 8'h11, 20, 1'b0, 1, 0, 8'h00};
    tbl[7]  = '{1'b0, 7'h00, 8'h00, 16, 1'b0, 0, 0, 8'h11};
    tbl[8]  = '{1'b0, 7'h03, 8'h00, 16, 1'b0, 0, 0, 8'hC3};
    tbl[9]  = '{1'b1, 7'h04, 8'hE7, 15, 1'b1, 0, 1, 8'h00};
    tbl[10] = '{1'b0, 7'h04, 8'h00, 16, 1'b0, 0, 0, 8'h5A};
    tbl[11] = '{1'b1, 7'h04, 8'hE7, 16, 1'b0, 1, 0, 8'h00};
    tbl[12] = '{1'b0, 7'h04, 8'h00, 16, 1'b0, 0, 0, 8'hE7};
    tbl[13] = '{1'b0, 7'h06, 8'h00, 18, 1'b0, 0, 0, 8'h00};

    for (int i = 0; i < 5; i++) model8[i] = RV8[i*8 +: 8];
    last8 = '0;
    pins(1'b0, 1'b0, 1'b0, 1'b1);
    pins(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset state
    wait_clk(3);
    chk("reset regs_flat", 80'(regs_flat8), 80'(RV8));
    chk("reset outputs", 80'({wr_strobe8, frame_err8, wr_addr8, if8.CIPO, if8.cipo_oe}), 80'(0));
    chk("reset regs16", 80'(regs_flat16), 80'(0));
    rst = 1'b0;
    wait_clk(10);

    for (int i = 0; i < 14; i++)
      run8($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].edges,
           tbl[i].coinc, tbl[i].exp_st, tbl[i].exp_er, tbl[i].exp_rd);

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
      data = 8'($urandom);
      r    = $urandom_range(0, 9);
      edges = (r < 6) ? 16 : (r < 8) ? $urandom_range(1, 15) : $urandom_range(17, 20);
      run8($sformatf("rnd%0d", n), wr, addr, data, edges, 1'b0,
           (edges >= 16 && wr && addr < 5) ? 1 : 0,
           (edges < 16 || (wr && addr >= 5)) ? 1 : 0,
           (addr < 5) ? model8[addr] : 8'h00);
    end

    // Reset in the data phase of write 0x80,0xFF
    st0 = st8; er0 = er8;
    f = 16'h80FF;
    pins(1'b0, 1'b0, 1'b0, 1'b0);
    wait_clk(HALF);
    for (int k = 0; k < 16; k++) begin
      if (k == 12) begin
        rst = 1'b1;
        wait_clk(2);
        chk("midframe reset regs", 80'(regs_flat8), 80'(RV8));
        chk("midframe reset outputs", 80'({wr_strobe8, frame_err8, wr_addr8, if8.CIPO, if8.cipo_oe}), 80'(0));
        rst = 1'b0;
        wait_clk(4);
      end
      pins(1'b0, 1'b0, f[15-k], 1'b0);
      wait_clk(HALF);
      pins(1'b0, 1'b1, f[15-k], 1'b0);
      wait_clk(HALF);
    end
    pins(1'b0, 1'b0, 1'b0, 1'b1);
    wait_clk(10);
    for (int i = 0; i < 5; i++) model8[i] = RV8[i*8 +: 8];
    last8 = '0;
    chk("abandoned frame strobe", 80'(st8 - st0), 80'(0));
    chk("abandoned frame ferr", 80'(er8 - er0), 80'(0));
    chk("abandoned frame regs", 80'(regs_flat8), 80'(RV8));
    run8("post-reset write", 1'b1, 7'h00, 8'h11, 16, 1'b0, 1, 0, 8'h00);

    // 16-bit instance
    st0 = st16; er0 = er16;
    do_frame(1'b1, 1'b1, 7'h04, 16'hBEEF, 24, 1'b0, rd, oe_ok, cipo_ok);
    chk("w16 strobe", 80'(st16 - st0), 80'(1));
    chk("w16 reg4", 80'(regs_flat16[64 +: 16]), 80'(16'hBEEF));
    chk("w16 wr_addr", 80'(wr_addr16), 80'(4));
    do_frame(1'b1, 1'b0, 7'h04, 16'h0000, 24, 1'b0, rd, oe_ok, cipo_ok);
    chk("r16 data", 80'(rd), 80'(16'hBEEF));
    chk("r16 cipo_zero_outside_data", 80'(cipo_ok), 80'(1));
    st0 = st16;
    do_frame(1'b1, 1'b1, 7'h03, 16'h1234, 28, 1'b0, rd, oe_ok, cipo_ok);
    chk("w16 long strobe", 80'(st16 - st0), 80'(1));
    chk("w16 long regs", 80'(regs_flat16), 80'({16'hBEEF, 16'h1234, 48'h0}));
    chk("w16 ferr total", 80'(er16 - er0), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
